// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: channel FSM encoding and
// default timing constants for a 50 MHz system clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int DEF_HOLD_CYCLES     = 50_000_000; // 1 s at 50 MHz

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce FSM with stable-cycle
// counter, and a long-press timer that fires key_hold once per press.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_raw_i,
  output logic       key_level_o,
  output logic       key_press_o,
  output logic       key_release_o,
  output logic       key_hold_o,
  output key_state_e state_o
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic s1_q, s2_q, key_s;
  key_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic fired_q, fired_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d, hold_q, hold_d;

  // XOR with the idle level normalizes to pressed=1 regardless of polarity.
  assign key_s = s2_q ^ IDLE_PIN;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q       <= IDLE_PIN;
      s2_q       <= IDLE_PIN;
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      fired_q    <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      s1_q       <= key_raw_i;
      s2_q       <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      fired_q    <= fired_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_cnt_d = hold_cnt_q;
    fired_d    = fired_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        // A falling key_s freezes the hold timer while the release is vetted.
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == HOLD_LAST && !fired_q) begin
            hold_d  = 1'b1;
            fired_d = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          level_d    = 1'b0;
          release_d  = 1'b1;
          hold_cnt_d = '0;
          fired_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_hold_o    = hold_q;
  assign state_o       = state_q;

  // A hold time inside the debounce window could never be distinguished.
  assert property (@(posedge clk_i) HOLD_CYCLES > DEBOUNCE_CYCLES);

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: one independent debounce channel per key,
// with per-channel FSM state exported for observation.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic       [KEY_NUM-1:0]     key_raw,
  output logic       [KEY_NUM-1:0]     key_level,
  output logic       [KEY_NUM-1:0]     key_press,
  output logic       [KEY_NUM-1:0]     key_release,
  output logic       [KEY_NUM-1:0]     key_hold,
  output key_state_e [KEY_NUM-1:0]     key_state
);

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk_i        (sys_clk),
      .rst_ni       (rst_n),
      .key_raw_i    (key_raw[k]),
      .key_level_o  (key_level[k]),
      .key_press_o  (key_press[k]),
      .key_release_o(key_release[k]),
      .key_hold_o   (key_hold[k]),
      .state_o      (key_state[k])
    );
  end

endmodule
